// File: rtl/pulse_period_meter.sv
// Measures the interval between pulse events on in, reporting it as a tick count
// (cycles between events minus 1), with lock detection and a sticky overflow flag.
module pulse_period_meter #(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         locked,
  output logic         overflow
);

  // state | meaning
  // IDLE  | no reference event yet; next event only arms
  // ARMED | counting enabled cycles since the last event
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  localparam int              MW        = $clog2(LOCK_COUNT) + 1;
  localparam logic [N-1:0]    CNT_MAX   = '1;
  localparam logic [MW-1:0]   MATCH_TOP = MW'(LOCK_COUNT - 1);

  logic [0:0]    r_state;
  logic [N-1:0]  r_counter;
  logic [N-1:0]  r_period;
  logic          r_valid;
  logic          r_locked;
  logic          r_overflow;
  logic [MW-1:0] r_match;
  logic          r_first;

  logic          w_event;
  logic [MW-1:0] w_match_next;

  assign w_event = ena & in;

  // The first measurement after arming has nothing valid to compare against.
  always_comb begin
    w_match_next = '0;
    if (!r_first && (r_counter == r_period)) begin
      if (r_match == MATCH_TOP) w_match_next = r_match;
      else                      w_match_next = r_match + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_counter  <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_overflow <= 1'b0;
      r_match    <= '0;
      r_first    <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      if (w_event) begin
        r_counter <= '0;
        if (r_state == S_IDLE) begin
          r_state <= S_ARMED;
          r_first <= 1'b1;
        end else begin
          r_valid    <= 1'b1;
          r_period   <= r_counter;
          r_overflow <= 1'b0;
          r_first    <= 1'b0;
          r_match    <= w_match_next;
          r_locked   <= (w_match_next == MATCH_TOP);
        end
      end else if (ena && (r_state == S_ARMED)) begin
        // An event at CNT_MAX is still a legal measurement; only a further idle cycle overflows.
        if (r_counter == CNT_MAX) begin
          r_state    <= S_IDLE;
          r_counter  <= '0;
          r_overflow <= 1'b1;
          r_locked   <= 1'b0;
          r_match    <= '0;
        end else begin
          r_counter <= r_counter + 1'b1;
        end
      end
    end
  end

  assign period   = r_period;
  assign valid    = r_valid;
  assign locked   = r_locked;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a history-based model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_pulse_period_meter;

  localparam int N    = 8;
  localparam int LC   = 4;
  localparam int MAXV = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         pin;
  logic [N-1:0] period;
  logic         valid;
  logic         locked;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  pulse_period_meter #(.N(N), .LOCK_COUNT(LC)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in       (pin),
    .period   (period),
    .valid    (valid),
    .locked   (locked),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed enabled cycles since the reference event, and the list of
  // measurements taken since the last arm. Locked means the last LC are equal.
  bit m_armed   = 0;
  int m_elapsed = 0;
  int m_hist[$];
  int exp_period = 0;
  int exp_valid  = 0;
  int exp_locked = 0;
  int exp_ovf    = 0;

  function automatic int hist_locked();
    int sz;
    sz = m_hist.size();
    if (sz < LC) return 0;
    for (int k = sz - LC; k < sz; k++)
      if (m_hist[k] != m_hist[sz - 1]) return 0;
    return 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_armed = 0; m_elapsed = 0; m_hist.delete();
        exp_period = 0; exp_valid = 0; exp_locked = 0; exp_ovf = 0;
      end else begin
        exp_valid = 0;
        if (ena && pin) begin
          if (m_armed) begin
            exp_valid  = 1;
            exp_period = m_elapsed;
            exp_ovf    = 0;
            m_hist.push_back(m_elapsed);
            if (m_hist.size() > LC) void'(m_hist.pop_front());
            exp_locked = hist_locked();
          end else begin
            m_armed = 1;
            m_hist.delete();
          end
          m_elapsed = 0;
        end else if (ena && m_armed) begin
          m_elapsed++;
          if (m_elapsed > MAXV) begin
            m_armed = 0; m_elapsed = 0; m_hist.delete();
            exp_ovf = 1; exp_locked = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cmp_valid",    int'(valid),    exp_valid);
        chk("cmp_period",   int'(period),   exp_period);
        chk("cmp_locked",   int'(locked),   exp_locked);
        chk("cmp_overflow", int'(overflow), exp_ovf);
      end
    end
  end

  task automatic cyc(input logic e, input logic i);
    ena = e;
    pin = i;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc(1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    int'(valid),    0);
    chk({tag, "_period"},   int'(period),   0);
    chk({tag, "_locked"},   int'(locked),   0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; pin = 1'b1;
    #3;
    chk_all_zero("rst0");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_pulse");
    rst = 1'b0;

    // First event after release only arms.
    cyc(1'b1, 1'b1);
    chk("arm_no_valid", int'(valid), 0);

    // Pulses every 6 cycles: period 5, locked on the 4th measurement.
    for (int p = 2; p <= 6; p++) begin
      gap(5);
      cyc(1'b1, 1'b1);
      chk("p6_valid",  int'(valid),  1);
      chk("p6_period", int'(period), 5);
      chk("p6_locked", int'(locked), (p >= 5) ? 1 : 0);
    end

    // Interval changes to 4 cycles: lock drops at once, returns on 4th match.
    for (int k = 1; k <= 4; k++) begin
      gap(3);
      cyc(1'b1, 1'b1);
      chk("p4_period", int'(period), 3);
      chk("p4_locked", int'(locked), (k == 4) ? 1 : 0);
    end

    // Disabled window with in high is ignored and excluded from the interval.
    gap(2);
    repeat (10) cyc(1'b0, 1'b1);
    chk("dis_no_valid", int'(valid), 0);
    chk("dis_hold_period", int'(period), 3);
    gap(3);
    cyc(1'b1, 1'b1);
    chk("dis_valid",  int'(valid),  1);
    chk("dis_period", int'(period), 5);

    // Overflow after the counter passes its maximum.
    gap(255);
    chk("ovf_not_yet", int'(overflow), 0);
    cyc(1'b1, 1'b0);
    chk("ovf_set",    int'(overflow), 1);
    chk("ovf_locked", int'(locked),   0);
    cyc(1'b1, 1'b1);
    chk("ovf_rearm_valid", int'(valid),    0);
    chk("ovf_rearm_keep",  int'(overflow), 1);
    gap(9);
    cyc(1'b1, 1'b1);
    chk("ovf_clr_valid",  int'(valid),    1);
    chk("ovf_clr_period", int'(period),   9);
    chk("ovf_clr_flag",   int'(overflow), 0);

    // in held high: period 0 every cycle, locked from the 4th valid.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1);
      chk("hold_valid",  int'(valid),  1);
      chk("hold_period", int'(period), 0);
      chk("hold_locked", int'(locked), (i >= 3) ? 1 : 0);
    end

    // Event exactly at the counter maximum is a legal measurement.
    gap(255);
    cyc(1'b1, 1'b1);
    chk("max_valid",    int'(valid),    1);
    chk("max_period",   int'(period),   255);
    chk("max_overflow", int'(overflow), 0);

    // Asynchronous reset mid-measurement discards the partial interval.
    gap(4);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    chk("rst_mid_arm", int'(valid), 0);
    gap(2);
    cyc(1'b1, 1'b1);
    chk("rst_mid_valid",  int'(valid),  1);
    chk("rst_mid_period", int'(period), 2);

    gap(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter N, default 8: width of the interval counter and of the period output.
REQ-002 Parameter LOCK_COUNT, default 4: number of consecutive identical measurements needed for lock; legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ena  input  1  count enable; when 0, the block ignores in and holds all state.
REQ-006 in  input  1  pulse input, synchronous to clk; every enabled cycle with in=1 is one pulse event.
REQ-007 period  output  N  last measured interval, expressed as the generator-style tick count: cycles between events minus 1.
REQ-008 valid  output  1  one-cycle strobe marking a new period value.
REQ-009 locked  output  1  high while the last LOCK_COUNT measurements were identical.
REQ-010 overflow  output  1  sticky flag: the interval exceeded counter range.

Function
REQ-011 States: IDLE (no reference event), ARMED (measuring from the last event).
REQ-012 Event = rising clk edge with ena=1 and in=1; no edge detection, so in held high gives one event per cycle.
REQ-013 IDLE + event -> ARMED, counter<=0, no valid, period unchanged.
REQ-014 ARMED + event -> valid<=1, period<=counter, counter<=0; the block stays ARMED.
REQ-015 ARMED + enabled non-event cycle with counter<2^N-1 -> counter<=counter+1, valid<=0.
REQ-016 ARMED + enabled non-event cycle with counter==2^N-1 -> IDLE, overflow<=1, locked<=0, match count<=0, counter<=0, no valid.
REQ-017 Event with counter==2^N-1 is a legal measurement (period=2^N-1); the event takes priority over overflow.
REQ-018 Latency: valid and period update on the same edge that samples the event, so they are visible during the following cycle; valid is low on every other cycle.
REQ-019 With pulses every T+1 enabled cycles (T<=2^N-1), period==T.
REQ-020 ena=0 cycles: counter, state and flags hold; valid<=0; in is ignored, and disabled cycles are excluded from period.
REQ-021 Match count, width ceil(log2(LOCK_COUNT))+1:
- on each valid measurement equal to the previous period, increment, saturating at LOCK_COUNT-1;
- on a differing measurement, or the first measurement after IDLE, load 0.
REQ-022 locked updates on the same edge as valid: 1 when match count reaches LOCK_COUNT-1, else 0.
REQ-023 A differing measurement drops locked on the same edge as its valid.
REQ-024 overflow clears on the next valid measurement; it is not cleared by IDLE re-arm alone.
REQ-025 The first measurement after overflow is never compared against the pre-overflow period.

Reset
REQ-026 Reset asserted (asynchronously): state=IDLE, counter=0, period=0, valid=0, locked=0, overflow=0, match count=0, independent of clk.
REQ-027 Reset mid-measurement discards the partial interval; the first event after release only arms.
REQ-028 Release is synchronous to clk: the first edge with rst=0 may sample an event.

Verification
REQ-029 Reset: assert rst between edges -> all outputs 0 immediately; pulse in during reset -> no valid after release until two events are seen.
REQ-030 N=8, ena=1, in pulses every 6 cycles -> no valid on pulse 1; valid with period=5 on pulses 2..n; locked=1 first with the valid of pulse 5 (4th measurement).
REQ-031 Locked at period=5, then interval changes to 4 cycles -> valid with period=3 and locked=0 on the same cycle; locked=1 again on the 4th period=3 measurement.
REQ-032 Armed, then no pulse for 256 cycles -> overflow=1 and locked=0 after counter passes 255.
- next pulse: no valid, overflow stays 1;
- following pulse 10 cycles later: valid, period=9, overflow=0.
REQ-033 Pulses 6 enabled cycles apart with ena=0 for 10 intervening cycles, plus in=1 during the disabled window -> period=5, no extra valid.
REQ-034 in held at 1 continuously -> valid every cycle from cycle 2 with period=0; locked from the 4th valid; event at counter=255 -> period=255, overflow=0.
